instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 64 ++++++
 rtl/instr_encoder_if.sv | 40 ++++
 rtl/instr_pack.sv | 61 ++++++
 rtl/instr_encoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg -- shared op, format and RV32I field constants (rev 1.0)
`default_nettype none

package instr_encoder_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_LW   = 4'd4,
      OP_LB   = 4'd5,
      OP_ADDI = 4'd6,
      OP_SW   = 4'd7,
      OP_SB   = 4'd8,
      OP_BEQ  = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      r_format = 2'd0,
      i_format = 2'd1,
      s_format = 2'd2,
      b_format = 2'd3
   } instr_format_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_LB      = 3'b000;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_SB      = 3'b000;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;

   function automatic instr_format_t format_of(input op_t op);
      instr_format_t fmt;
      case (op)
         OP_LW, OP_LB, OP_ADDI: fmt = i_format;
         OP_SW, OP_SB:          fmt = s_format;
         OP_BEQ:                fmt = b_format;
         default:               fmt = r_format;
      endcase
      return fmt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// instr_encoder_if -- load-session handshake and instruction-memory write bus (rev 1.0)
`default_nettype none

interface instr_encoder_if #(
   parameter int DEPTH = 256
);
   import instr_encoder_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic          start;
   logic          finish;
   logic          in_valid;
   logic          in_ready;
   op_t           in_op;
   logic [4:0]    in_rd;
   logic [4:0]    in_rs1;
   logic [4:0]    in_rs2;
   logic [12:0]   in_imm;
   logic          imem_we;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_wdata;
   logic [CW-1:0] count;
   logic          busy;
   logic          full;
   logic          err;

   modport master (
      output start, finish, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, full, err
   );

   modport slave (
      input  start, finish, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
      output in_ready, imem_we, imem_addr, imem_wdata, count, busy, full, err
   );

endinterface

`default_nettype wire

// File: rtl/instr_pack.sv
// instr_pack -- combinational RV32I word packer with illegal-operand detection (rev 1.0)
`default_nettype none

module instr_pack
   import instr_encoder_pkg::*;
(
   input  op_t         op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   instr_format_t fmt;
   logic          imm_fits_12;

   assign fmt = format_of(op);
   // A 13-bit value fits in 12 signed bits only when its top two bits agree.
   assign imm_fits_12 = (imm[12] == imm[11]);

   always_comb begin
      opcode  = OPC_OP;
      funct3  = F3_ADD_SUB;
      funct7  = F7_BASE;
      illegal = 1'b0;
      case (op)
         OP_ADD:  funct3 = F3_ADD_SUB;
         OP_SUB:  funct7 = F7_SUB;
         OP_AND:  funct3 = F3_AND;
         OP_OR:   funct3 = F3_OR;
         OP_LW:   begin opcode = OPC_LOAD;   funct3 = F3_LW;   end
         OP_LB:   begin opcode = OPC_LOAD;   funct3 = F3_LB;   end
         OP_ADDI: begin opcode = OPC_OPIMM;  funct3 = F3_ADDI; end
         OP_SW:   begin opcode = OPC_STORE;  funct3 = F3_SW;   end
         OP_SB:   begin opcode = OPC_STORE;  funct3 = F3_SB;   end
         OP_BEQ:  begin opcode = OPC_BRANCH; funct3 = F3_BEQ;  end
         default: illegal = 1'b1;
      endcase

      case (fmt)
         i_format, s_format: if (!imm_fits_12) illegal = 1'b1;
         b_format:           if (imm[0])       illegal = 1'b1;
         default:            ;
      endcase

      case (fmt)
         i_format: word = {imm[11:0], rs1, funct3, rd, opcode};
         s_format: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         b_format: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         default:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// instr_encoder -- session FSM that encodes instruction fields and streams them into instruction memory (rev 1.0)
`default_nettype none

module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
)
(
   input  logic clk,
   input  logic rst_n,
   instr_encoder_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t        state;
   logic [CW-1:0] count_q;
   logic [31:0]   wr_ptr;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          err_q;
   logic          full_q;
   logic          busy_q;

   logic [31:0]   word;
   logic          illegal;
   logic          accept;
   logic          do_write;
   logic          last_word;

   instr_pack u_pack (
      .op      (bus.in_op),
      .rd      (bus.in_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .imm     (bus.in_imm),
      .word    (word),
      .illegal (illegal)
   );

   // The DEPTH-th write moves the FSM to S_DONE on the same edge it lands,
   // so there is never a cycle where a final word is accepted but not yet counted.
   assign bus.in_ready = (state == S_LOAD) && !full_q;
   assign accept       = bus.in_valid && bus.in_ready;
   assign do_write     = accept && !illegal;
   assign last_word    = do_write && (count_q == CW'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         count_q <= '0;
         wr_ptr  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         we_q   <= do_write;
         err_q  <= accept && illegal;
         busy_q <= do_write;
         if (do_write) begin
            addr_q  <= wr_ptr;
            wdata_q <= word;
            wr_ptr  <= wr_ptr + 32'd4;
            count_q <= count_q + CW'(1);
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state   <= S_LOAD;
                  count_q <= '0;
                  wr_ptr  <= BASE_ADDR;
                  full_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (last_word) begin
                  state  <= S_DONE;
                  full_q <= 1'b1;
               end else if (bus.finish) begin
                  state  <= S_DONE;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.count      = count_q;
   assign bus.busy       = busy_q;
   assign bus.full       = full_q;
   assign bus.err        = err_q;

endmodule

`default_nettype wire
